rtmc_reg_arb: RTL and testbench

Round-robin arbiter and sequencer for the rtmc register bus. It shares the single register target (register file / peripheral CSRs) between `NREQ` requesters, for example the SPI slave and the on-chip motion sequencer. Each requester gets a held-request/pulse-acknowledge interface, and the arbiter drives one strobed transaction at a time onto the bus. It sits in `rtmc_core` between the requesters and the register target, and it converts a missing target acknowledge into an error completion so no requester can hang.

---
 rtl/rtmc_pkg.sv | 17 +
 rtl/rtmc_reg_arb_if.sv | 33 +++
 rtl/rtmc_rr_pick.sv | 28 ++
 rtl/rtmc_reg_arb.sv | 98 +++++++++
 tb/tb_rtmc_reg_arb.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtmc_pkg.sv
// Shared rtmc definitions: bus widths, arbiter state encoding and defaults.
package rtmc_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Default number of cycles the arbiter waits for a target ack.
    localparam int unsigned ARB_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_t;

endpackage

// File: rtl/rtmc_reg_arb_if.sv
// Requester-side and register-target-side signals of the rtmc register arbiter.
// master: the arbiter. slave: the requesters and the register target.
interface rtmc_reg_arb_if #(
    parameter int unsigned NREQ = 2
);
    import rtmc_pkg::*;

    logic [NREQ-1:0]        req_wr;
    logic [NREQ-1:0]        req_rd;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdat;
    logic [NREQ-1:0]        req_ack;
    logic                   req_err;
    logic [DATA_W-1:0]      req_rdat;

    logic [ADDR_W-1:0]      reg_addr;
    logic [DATA_W-1:0]      reg_wdat;
    logic                   reg_wr;
    logic                   reg_rd;
    logic [DATA_W-1:0]      reg_rdat;
    logic                   reg_ack;

    modport master (
        input  req_wr, req_rd, req_addr, req_wdat, reg_rdat, reg_ack,
        output req_ack, req_err, req_rdat, reg_addr, reg_wdat, reg_wr, reg_rd
    );

    modport slave (
        output req_wr, req_rd, req_addr, req_wdat, reg_rdat, reg_ack,
        input  req_ack, req_err, req_rdat, reg_addr, reg_wdat, reg_wr, reg_rd
    );

endinterface

// File: rtl/rtmc_rr_pick.sv
// Combinational round-robin picker: first pending index after `last`, wrapping.
module rtmc_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Scan from lowest priority (last itself) to highest (last+1); the final hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = int'(N); k >= 1; k--) begin
            pos = IW'((int'(last) + k) % int'(N));
            if (pending[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rtmc_reg_arb.sv
// Round-robin arbiter/sequencer sharing one register target between NREQ requesters.
// A missing target ack turns into an error completion after TIMEOUT cycles of waiting.
module rtmc_reg_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = rtmc_pkg::ARB_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    rtmc_reg_arb_if.master bus
);
    import rtmc_pkg::*;

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t      state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   grant;
    logic            is_wr;
    logic [7:0]      cnt;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] grant_oh;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            timed_out;

    assign pending   = bus.req_wr | bus.req_rd;
    assign grant_oh  = {{(NREQ-1){1'b0}}, 1'b1} << grant;
    assign timed_out = (cnt == 8'(TIMEOUT));

    rtmc_rr_pick #(
        .N (NREQ)
    ) u_pick (
        .pending (pending),
        .last    (last),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Transaction sequencer; every requester and bus output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            last         <= IW'(NREQ - 1);
            grant        <= '0;
            is_wr        <= 1'b0;
            cnt          <= '0;
            bus.req_ack  <= '0;
            bus.req_err  <= 1'b0;
            bus.req_rdat <= '0;
            bus.reg_addr <= '0;
            bus.reg_wdat <= '0;
            bus.reg_wr   <= 1'b0;
            bus.reg_rd   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (pick_valid) begin
                        grant        <= pick_idx;
                        last         <= pick_idx;
                        // Write wins when a requester raises both ops.
                        is_wr        <= bus.req_wr[pick_idx];
                        bus.reg_wr   <= bus.req_wr[pick_idx];
                        bus.reg_rd   <= ~bus.req_wr[pick_idx];
                        bus.reg_addr <= bus.req_addr[int'(pick_idx) * int'(ADDR_W) +: ADDR_W];
                        bus.reg_wdat <= bus.req_wdat[int'(pick_idx) * int'(DATA_W) +: DATA_W];
                        state        <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    bus.reg_wr <= 1'b0;
                    bus.reg_rd <= 1'b0;
                    if (bus.reg_ack) begin
                        bus.req_ack  <= grant_oh;
                        bus.req_err  <= 1'b0;
                        bus.req_rdat <= is_wr ? '0 : bus.reg_rdat;
                        state        <= StDone;
                    end else if (state == StWait && timed_out) begin
                        bus.req_ack  <= grant_oh;
                        bus.req_err  <= 1'b1;
                        bus.req_rdat <= '1;
                        state        <= StDone;
                    end else begin
                        // Count starts at 1 in the first WAIT cycle.
                        cnt   <= (state == StIssue) ? 8'd1 : cnt + 8'd1;
                        state <= StWait;
                    end
                end
                StDone: begin
                    bus.req_ack <= '0;
                    bus.req_err <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rtmc_reg_arb.sv
// Directed bench for rtmc_reg_arb with a strobe/completion scoreboard and a simple target.
module tb_rtmc_reg_arb;
    import rtmc_pkg::*;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rtmc_reg_arb_if #(.NREQ(NREQ)) bus ();

    rtmc_reg_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
    } strobe_t;

    typedef struct {
        logic [NREQ-1:0]   ack;
        logic              err;
        logic [DATA_W-1:0] rdat;
    } cpl_t;

    strobe_t exp_strobe[$];
    cpl_t    exp_cpl[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tgt_lat = 0;
    int tgt_cnt = -1;
    logic [DATA_W-1:0] tgt_rdat = '0;
    int strobe_cyc = -1;
    int ack_cyc = -1;
    int ack_total = 0;
    int hold_acks = 0;
    int rc = 0;
    logic [ADDR_W-1:0] held_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_strobe(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
        strobe_t s;
        s.wr = wr; s.rd = rd; s.addr = a; s.wdat = d;
        exp_strobe.push_back(s);
    endtask

    task automatic push_cpl(input logic [NREQ-1:0] ack, input logic err,
                            input logic [DATA_W-1:0] rdat);
        cpl_t c;
        c.ack = ack; c.err = err; c.rdat = rdat;
        exp_cpl.push_back(c);
    endtask

    task automatic request(input int idx, input logic wr, input logic rd,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_wr[idx] = wr;
        bus.req_rd[idx] = rd;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = a;
        bus.req_wdat[idx*DATA_W +: DATA_W] = d;
    endtask

    // One clock: sample outputs, score strobes/completions, play the target, retire requests.
    task automatic step();
        strobe_t s;
        cpl_t    c;
        @(posedge clk);
        #1;
        cyc++;
        bus.reg_ack = 1'b0;
        if (bus.reg_wr || bus.reg_rd) begin
            strobe_cyc = cyc;
            if (exp_strobe.size() == 0) begin
                check("unexpected_strobe", {bus.reg_wr, bus.reg_rd}, 0);
            end else begin
                s = exp_strobe.pop_front();
                check("strobe_op", {bus.reg_wr, bus.reg_rd}, {s.wr, s.rd});
                check("strobe_addr", bus.reg_addr, s.addr);
                check("strobe_wdat", bus.reg_wdat, s.wdat);
            end
            held_addr = bus.reg_addr;
            tgt_cnt = tgt_lat;
        end else if (tgt_cnt > 0) begin
            tgt_cnt--;
            check("addr_stable", bus.reg_addr, held_addr);
        end
        if (tgt_cnt == 0) begin
            bus.reg_ack  = 1'b1;
            bus.reg_rdat = tgt_rdat;
            tgt_cnt = -1;
        end
        if (bus.req_ack != '0) begin
            ack_cyc = cyc;
            ack_total++;
            if (exp_cpl.size() == 0) begin
                check("unexpected_ack", bus.req_ack, 0);
            end else begin
                c = exp_cpl.pop_front();
                check("cpl_ack", bus.req_ack, c.ack);
                check("cpl_err", bus.req_err, c.err);
                check("cpl_rdat", bus.req_rdat, c.rdat);
            end
            if (hold_acks > 0) begin
                hold_acks--;
                if (hold_acks == 0) begin
                    bus.req_wr = '0;
                    bus.req_rd = '0;
                end
            end else begin
                bus.req_wr = bus.req_wr & ~bus.req_ack;
                bus.req_rd = bus.req_rd & ~bus.req_ack;
            end
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        int k;
        target = ack_total + n;
        k = 0;
        while (ack_total < target && k < budget) begin
            step();
            k++;
        end
        if (ack_total < target) check("ack_wait_expired", ack_total, target);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.req_ack, bus.req_err, bus.req_rdat, bus.reg_addr, bus.reg_wdat,
                    bus.reg_wr, bus.reg_rd}, 0);
    endtask

    initial begin
        bus.req_wr   = '0;
        bus.req_rd   = '0;
        bus.req_addr = '0;
        bus.req_wdat = '0;
        bus.reg_rdat = '0;
        bus.reg_ack  = 1'b0;

        // Reset state
        #1;
        check_all_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single write, same-cycle target ack
        tgt_lat = 0;
        tgt_rdat = 8'h5A;
        push_strobe(1'b1, 1'b0, 8'd3, 8'hA5);
        push_cpl(2'b01, 1'b0, 8'h00);
        request(0, 1'b1, 1'b0, 8'd3, 8'hA5);
        rc = cyc;
        wait_acks(1, 10);
        check("t1_strobe_cycle", strobe_cyc, rc + 1);
        check("t1_ack_cycle", ack_cyc, rc + 2);
        check("t1_strobe_one_cycle", bus.reg_wr, 1'b0);
        step();
        check("t1_ack_pulse", bus.req_ack, 2'b00);

        // Read with ack four cycles after the strobe
        tgt_lat = 4;
        tgt_rdat = 8'h3C;
        push_strobe(1'b0, 1'b1, 8'd5, 8'h00);
        push_cpl(2'b10, 1'b0, 8'h3C);
        request(1, 1'b0, 1'b1, 8'd5, 8'h00);
        wait_acks(1, 12);
        check("t2_ack_cycle", ack_cyc, strobe_cyc + 5);
        step();
        check("t2_rdat_hold", bus.req_rdat, 8'h3C);

        // Contention: both held for four transactions
        tgt_lat = 1;
        tgt_rdat = 8'h66;
        for (int i = 0; i < 2; i++) begin
            push_strobe(1'b1, 1'b0, 8'h10, 8'h11);
            push_strobe(1'b0, 1'b1, 8'h20, 8'h22);
            push_cpl(2'b01, 1'b0, 8'h00);
            push_cpl(2'b10, 1'b0, 8'h66);
        end
        hold_acks = 4;
        request(0, 1'b1, 1'b0, 8'h10, 8'h11);
        request(1, 1'b0, 1'b1, 8'h20, 8'h22);
        wait_acks(4, 40);
        check("t3_all_served", exp_cpl.size(), 0);
        step();

        // Timeout with no target ack, then a stray ack in IDLE
        tgt_lat = -1;
        push_strobe(1'b0, 1'b1, 8'h0C, 8'h00);
        push_cpl(2'b01, 1'b1, 8'hFF);
        request(0, 1'b0, 1'b1, 8'h0C, 8'h00);
        wait_acks(1, 30);
        check("t4_ack_cycle", ack_cyc, strobe_cyc + TIMEOUT + 1);
        step();
        bus.reg_ack = 1'b1;
        step();
        step();
        step();
        check("t4_stray_no_strobe", {bus.reg_wr, bus.reg_rd}, 0);
        check("t4_stray_no_ack", {bus.req_ack, bus.req_err}, 0);
        check("t4_rdat_hold", bus.req_rdat, 8'hFF);

        // Write and read raised together: write only
        tgt_lat = 2;
        tgt_rdat = 8'h55;
        push_strobe(1'b1, 1'b0, 8'h42, 8'h99);
        push_cpl(2'b10, 1'b0, 8'h00);
        request(1, 1'b1, 1'b1, 8'h42, 8'h99);
        wait_acks(1, 12);
        step();

        // Reset during WAIT, then requester 0 must win first
        tgt_lat = -1;
        push_strobe(1'b0, 1'b1, 8'h07, 8'h00);
        request(0, 1'b0, 1'b1, 8'h07, 8'h00);
        step();
        step();
        step();
        check("t6_in_flight", exp_strobe.size(), 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset_outputs");
        bus.req_wr = '0;
        bus.req_rd = '0;
        bus.reg_ack = 1'b0;
        tgt_cnt = -1;
        exp_strobe.delete();
        exp_cpl.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tgt_lat = 0;
        push_strobe(1'b1, 1'b0, 8'h01, 8'h01);
        push_strobe(1'b1, 1'b0, 8'h02, 8'h02);
        push_cpl(2'b01, 1'b0, 8'h00);
        push_cpl(2'b10, 1'b0, 8'h00);
        hold_acks = 2;
        request(0, 1'b1, 1'b0, 8'h01, 8'h01);
        request(1, 1'b1, 1'b0, 8'h02, 8'h02);
        wait_acks(2, 20);
        step();

        check("final_strobe_queue", exp_strobe.size(), 0);
        check("final_cpl_queue", exp_cpl.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
